// File: rtl/rs232_txd_arbiter.sv
// Round-robin arbiter and 8N1 serializer sharing one RS232 Txd line among NREQ byte producers.
// Define RS232_TXARB_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module rs232_txd_arbiter #(
  parameter int NREQ      = 4,
  parameter int BIT_TICKS = 16
) (
  input  logic              Clock16x,
  input  logic              Reset,
  input  logic [NREQ-1:0]   ReqValid,
  input  logic [8*NREQ-1:0] ReqData,
  output logic [NREQ-1:0]   ReqReady,
  output logic              Txd,
  output logic              Busy,
  output logic [1:0]        GrantId
);

  localparam int TW = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(BIT_TICKS - 1);

  localparam logic [2:0] stIdle   = 3'd0;
  localparam logic [2:0] stStart  = 3'd1;
  localparam logic [2:0] stData   = 3'd2;
  localparam logic [2:0] stStop   = 3'd3;
`ifdef RS232_TXARB_PARITY_EN
  localparam logic [2:0] stParity = 3'd4;
`endif

  logic [2:0]    r_state;
  logic [TW-1:0] r_tick;
  logic [2:0]    r_bitcnt;
  logic [7:0]    r_shift;
  logic [1:0]    r_ptr;
  logic          r_txd;
  logic          r_busy;
  logic [1:0]    r_grant_id;
`ifdef RS232_TXARB_PARITY_EN
  logic          r_parity;
`endif

  logic            w_any;
  logic [1:0]      w_win_id;
  logic [NREQ-1:0] w_win_oh;
  logic [7:0]      w_win_data;
  logic [1:0]      w_next_ptr;
  logic            w_tick_wrap;

  // First valid requester scanning upward from the pointer, wrapping at NREQ.
  always_comb begin
    w_any    = 1'b0;
    w_win_id = 2'd0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = int'(r_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!w_any && ReqValid[idx]) begin
        w_any    = 1'b1;
        w_win_id = 2'(idx);
      end
    end
  end

  assign w_win_oh    = w_any ? (NREQ'(1) << w_win_id) : '0;
  assign w_win_data  = ReqData[{w_win_id, 3'b000} +: 8];
  assign w_next_ptr  = (int'(w_win_id) == NREQ - 1) ? 2'd0 : w_win_id + 2'd1;
  assign w_tick_wrap = (r_tick == TICK_LAST);

  // Grant is only offered while idle and never while reset is being sampled.
  assign ReqReady = ((r_state == stIdle) && !Reset) ? w_win_oh : '0;
  assign Txd      = r_txd;
  assign Busy     = r_busy;
  assign GrantId  = r_grant_id;

  always_ff @(posedge Clock16x) begin
    if (Reset) begin
      r_state    <= stIdle;
      r_tick     <= '0;
      r_bitcnt   <= 3'd0;
      r_shift    <= 8'd0;
      r_ptr      <= 2'd0;
      r_txd      <= 1'b1;
      r_busy     <= 1'b0;
      r_grant_id <= 2'd0;
`ifdef RS232_TXARB_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      case (r_state)
        stIdle: begin
          if (w_any) begin
            r_shift    <= w_win_data;
            r_grant_id <= w_win_id;
            r_ptr      <= w_next_ptr;
            r_txd      <= 1'b0;
            r_busy     <= 1'b1;
            r_tick     <= '0;
            r_bitcnt   <= 3'd0;
            r_state    <= stStart;
`ifdef RS232_TXARB_PARITY_EN
            r_parity   <= ^w_win_data;
`endif
          end
        end
        stStart: begin
          if (w_tick_wrap) begin
            r_tick  <= '0;
            r_txd   <= r_shift[0];
            r_state <= stData;
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end
        stData: begin
          if (w_tick_wrap) begin
            r_tick <= '0;
            if (r_bitcnt == 3'd7) begin
`ifdef RS232_TXARB_PARITY_EN
              r_txd   <= r_parity;
              r_state <= stParity;
`else
              r_txd   <= 1'b1;
              r_state <= stStop;
`endif
            end else begin
              // Txd is registered, so the next bit is taken one position ahead.
              r_bitcnt <= r_bitcnt + 3'd1;
              r_shift  <= r_shift >> 1;
              r_txd    <= r_shift[1];
            end
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end
`ifdef RS232_TXARB_PARITY_EN
        stParity: begin
          if (w_tick_wrap) begin
            r_tick  <= '0;
            r_txd   <= 1'b1;
            r_state <= stStop;
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end
`endif
        stStop: begin
          if (w_tick_wrap) begin
            r_tick  <= '0;
            r_busy  <= 1'b0;
            r_state <= stIdle;
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end
        default: begin
          r_tick  <= '0;
          r_txd   <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= stIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rs232_txd_arbiter.sv
// Scoreboard bench for rs232_txd_arbiter: a round-robin grant model feeds expected frames to a serial-line monitor.
module tb_rs232_txd_arbiter;
  localparam int NREQ = 4;
  localparam int BT   = 16;
`ifdef RS232_TXARB_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * BT;

  logic              Clock16x = 1'b0;
  logic              Reset    = 1'b1;
  logic [NREQ-1:0]   ReqValid = '0;
  logic [8*NREQ-1:0] ReqData  = '0;
  logic [NREQ-1:0]   ReqReady;
  logic              Txd;
  logic              Busy;
  logic [1:0]        GrantId;

  rs232_txd_arbiter #(.NREQ(NREQ), .BIT_TICKS(BT)) dut (
    .Clock16x(Clock16x),
    .Reset(Reset),
    .ReqValid(ReqValid),
    .ReqData(ReqData),
    .ReqReady(ReqReady),
    .Txd(Txd),
    .Busy(Busy),
    .GrantId(GrantId)
  );

  always #5 Clock16x = ~Clock16x;

  typedef struct {
    int         id;
    logic [7:0] data;
    int         t;
  } frame_t;

  frame_t exp_q[$];
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge Clock16x) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  // Reference arbiter: a requester list, a priority pointer and a frame-length countdown.
  int              m_ptr  = 0;
  int              m_busy = 0;
  logic [NREQ-1:0] tb_hs  = '0;

  always @(negedge Clock16x) begin
    logic [NREQ-1:0] exp_rr;
    frame_t          f;
    exp_rr = '0;
    if (Reset) begin
      m_ptr  = 0;
      m_busy = 0;
    end else if (m_busy > 0) begin
      m_busy = m_busy - 1;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (m_ptr + k) % NREQ;
        if (exp_rr == '0 && ReqValid[idx]) begin
          exp_rr[idx] = 1'b1;
          f.id   = idx;
          f.data = ReqData[8*idx +: 8];
          f.t    = cyc;
          exp_q.push_back(f);
          m_ptr  = (idx + 1) % NREQ;
          m_busy = FRAME;
        end
      end
    end
    check("ReqReady", int'(ReqReady), int'(exp_rr));
    tb_hs = ReqValid & ReqReady;
  end

  // Line monitor: pops an expected frame when Busy rises and checks every cycle of it.
  logic   prev_rst   = 1'b1;
  int     mon_pos    = 0;
  int     last_id    = 0;
  int     frames_done = 0;
  frame_t cur;

  always @(negedge Clock16x) begin
    if (prev_rst) begin
      check("reset_txd", int'(Txd), 1);
      check("reset_busy", int'(Busy), 0);
      check("reset_grantid", int'(GrantId), 0);
      mon_pos = 0;
      last_id = 0;
    end else if (mon_pos == 0) begin
      if (Busy) begin
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 1, 0);
        end else begin
          cur = exp_q.pop_front();
          check("frame_start_cycle", cyc, cur.t + 1);
          mon_pos = 1;
          last_id = cur.id;
        end
      end else begin
        check("idle_txd", int'(Txd), 1);
        check("idle_grantid", int'(GrantId), last_id);
      end
    end
    if (!prev_rst && mon_pos > 0) begin
      int b;
      int eb;
      b = (mon_pos - 1) / BT;
      if (b == 0) eb = 0;
      else if (b <= 8) eb = int'(cur.data[b-1]);
      else if (b == 9 && NBITS == 11) eb = int'(^cur.data);
      else eb = 1;
      check("txd_bit", int'(Txd), eb);
      check("frame_busy", int'(Busy), 1);
      check("frame_grantid", int'(GrantId), cur.id);
      mon_pos++;
      if (mon_pos > FRAME) begin
        mon_pos = 0;
        frames_done++;
      end
    end
    prev_rst = Reset;
  end

  // Requester behaviour after its handshake: 0 drop, 1 re-arm with new byte, 2 drop and scribble 0xFF.
  int mode [NREQ];
  bit rand_en = 1'b0;

  task automatic step();
    @(posedge Clock16x);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (tb_hs[i]) begin
        case (mode[i])
          1: ReqData[8*i +: 8] = 8'($urandom);
          2: begin
            ReqValid[i]       = 1'b0;
            ReqData[8*i +: 8] = 8'hFF;
          end
          default: ReqValid[i] = 1'b0;
        endcase
      end
    end
    if (rand_en) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!ReqValid[i] && $urandom_range(0, 15) == 0) begin
          ReqData[8*i +: 8] = 8'($urandom);
          ReqValid[i]       = 1'b1;
        end
      end
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) step();
  endtask

  task automatic pulse_reset(input int n);
    Reset = 1'b1;
    wait_cycles(n);
    Reset = 1'b0;
  endtask

  initial begin
    bit got;
    for (int i = 0; i < NREQ; i++) mode[i] = 0;
    wait_cycles(3);
    Reset = 1'b0;

    ReqData[7:0] = 8'h55;
    ReqValid     = 4'b0001;
    wait_cycles(FRAME + 20);

    pulse_reset(2);
    ReqData  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    ReqValid = 4'b1111;
    wait_cycles(4 * (FRAME + 1) + 20);

    mode[0] = 1;
    mode[2] = 1;
    ReqValid = 4'b0101;
    wait_cycles(6 * (FRAME + 1));
    ReqValid = 4'b0000;
    mode[0] = 0;
    mode[2] = 0;
    wait_cycles(FRAME + 10);

    ReqData[31:24] = 8'h3C;
    ReqValid[3]    = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      step();
      if (tb_hs != '0) got = 1'b1;
    end
    if (!got) check("grant_timeout", 0, 1);
    wait_cycles(69);
    ReqData[15:8]  = 8'hC1;
    ReqData[31:24] = 8'hC3;
    ReqValid       = 4'b1010;
    pulse_reset(1);
    wait_cycles(2 * (FRAME + 1) + 10);

    mode[0]      = 2;
    ReqData[7:0] = 8'h0F;
    ReqValid[0]  = 1'b1;
    wait_cycles(FRAME + 20);
    mode[0] = 0;

    ReqData[7:0] = 8'h07;
    ReqValid[0]  = 1'b1;
    wait_cycles(FRAME + 20);

    rand_en = 1'b1;
    wait_cycles(2000 + int'($urandom_range(0, 150)));
    pulse_reset(1 + int'($urandom_range(0, 2)));
    wait_cycles(2000);
    rand_en = 1'b0;
    wait_cycles(5 * (FRAME + 1) + 10);

    check("queue_drained", exp_q.size(), 0);
    check("monitor_idle", mon_pos, 0);
    check("frames_seen", int'(frames_done > 10), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
